// File: rtl/clk_seq_pkg.sv
// Shared constants, state encoding and half-period table for the clock-rate sequencer.
package clk_seq_pkg;

    localparam int unsigned NUM_RATES = 32'd9;
    localparam int unsigned SEL_W     = 32'd4;
    localparam int unsigned CTR_W     = 32'd26;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } seq_state_e;

    // Decade-spaced output frequencies; invalid indices map to 1 Hz so the table never divides by zero.
    function automatic int unsigned rate_hz(input logic [SEL_W-1:0] sel);
        int unsigned f;
        case (sel)
            4'd0:    f = 32'd50_000_000;
            4'd1:    f = 32'd10_000_000;
            4'd2:    f = 32'd1_000_000;
            4'd3:    f = 32'd100_000;
            4'd4:    f = 32'd10_000;
            4'd5:    f = 32'd1_000;
            4'd6:    f = 32'd100;
            4'd7:    f = 32'd10;
            4'd8:    f = 32'd1;
            default: f = 32'd1;
        endcase
        return f;
    endfunction

    function automatic logic [CTR_W-1:0] half_of(input int unsigned clk_hz,
                                                 input logic [SEL_W-1:0] sel);
        int unsigned q;
        q = clk_hz / (32'd2 * rate_hz(sel));
        return q[CTR_W-1:0];
    endfunction

endpackage

// File: rtl/clk_seq_divider.sv
// Half-period counter, square-wave toggle and rise tick; flags the coming toggle to the controller.
module clk_seq_divider
    import clk_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CTR_W-1:0] half_cnt,
    input  logic             run,
    input  logic             load,
    output logic             clk_out,
    output logic             tick,
    output logic             rise_next,
    output logic             fall_next
);

    logic [CTR_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             at_end_s;

    assign at_end_s  = (cnt_q == (half_cnt - CTR_W'(1)));
    assign rise_next = run & at_end_s & ~clk_q;
    assign fall_next = run & at_end_s & clk_q;
    assign clk_out   = clk_q;
    assign tick      = tick_q;

    // Next counter/phase; load clears the count while keeping the current (low) level.
    always_comb begin
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (!run) begin
            cnt_d = '0;
            clk_d = 1'b0;
        end else if (load) begin
            cnt_d = '0;
        end else if (at_end_s) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            tick_d = ~clk_q;
        end else begin
            cnt_d = cnt_q + CTR_W'(1);
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/clk_rate_sequencer.sv
// Selectable-rate clock/tick generator with glitch-free req/ack rate switching.
// Optional tick counter enabled by defining CLKSEQ_TICK_COUNT_EN.
module clk_rate_sequencer
    import clk_seq_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 32'd100_000_000,
    parameter int unsigned RESET_SEL = 32'd5
)
(
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic             en,
    input  logic [SEL_W-1:0] rate_sel,
    input  logic             req,
    output logic             ack,
    output logic             err,
    output logic             busy,
    output logic [SEL_W-1:0] cur_sel,
    output logic             clk_out,
    output logic             tick,
    output logic [15:0]      tick_count
);

    seq_state_e       state_q, state_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             load_s, run_s, accept_s;
    logic             rise_next_s, fall_next_s, clk_out_s, tick_s;
    logic [CTR_W-1:0] half_cnt_s;

    assign half_cnt_s = half_of(CLK_HZ, cur_sel_q);
    assign run_s      = (state_q != STOP);
    assign accept_s   = req & ~busy_q;

    clk_seq_divider u_div (
        .clk       (CLK100MHZ),
        .rst_n     (CPU_RESETN),
        .half_cnt  (half_cnt_s),
        .run       (run_s),
        .load      (load_s),
        .clk_out   (clk_out_s),
        .tick      (tick_s),
        .rise_next (rise_next_s),
        .fall_next (fall_next_s)
    );

    // Controller next state: stop/switch rules first, then a freshly accepted request layered on top.
    always_comb begin
        state_d    = state_q;
        cur_sel_d  = cur_sel_q;
        pend_sel_d = pend_sel_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        load_s     = 1'b0;
        case (state_q)
            STOP: begin
                if (en) begin
                    state_d = RUN;
                end else begin
                    state_d = STOP;
                end
            end
            RUN: begin
                if (!en && !clk_out_s) begin
                    state_d = STOP;
                    load_s  = 1'b1;
                end else if (!en && fall_next_s) begin
                    state_d = STOP;
                end else begin
                    state_d = RUN;
                end
            end
            PEND: begin
                // A rising event always completes the switch, even if en dropped this cycle.
                if (rise_next_s) begin
                    cur_sel_d = pend_sel_q;
                    ack_d     = 1'b1;
                    state_d   = RUN;
                end else if (!en && (!clk_out_s || fall_next_s)) begin
                    cur_sel_d = pend_sel_q;
                    ack_d     = 1'b1;
                    state_d   = STOP;
                    load_s    = ~clk_out_s;
                end else begin
                    state_d = PEND;
                end
            end
            default: begin
                state_d = STOP;
            end
        endcase

        if (accept_s) begin
            if (rate_sel >= SEL_W'(NUM_RATES)) begin
                ack_d = 1'b1;
                err_d = 1'b1;
            end else if ((rate_sel == cur_sel_q) || (state_q == STOP) || (state_d == STOP)) begin
                cur_sel_d = rate_sel;
                ack_d     = 1'b1;
            end else begin
                pend_sel_d = rate_sel;
                state_d    = PEND;
            end
        end else begin
            pend_sel_d = pend_sel_q;
        end

        busy_d = (state_d == PEND);
    end

    // Controller registers; reset drops any pending request silently.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q    <= STOP;
            cur_sel_q  <= SEL_W'(RESET_SEL);
            pend_sel_q <= SEL_W'(RESET_SEL);
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_sel_q  <= cur_sel_d;
            pend_sel_q <= pend_sel_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign ack     = ack_q;
    assign err     = err_q;
    assign busy    = busy_q;
    assign cur_sel = cur_sel_q;
    assign clk_out = clk_out_s;
    assign tick    = tick_s;

`ifdef CLKSEQ_TICK_COUNT_EN
    logic [15:0] tick_count_q, tick_count_d;

    // Saturating tick counter, restarted whenever an ack changes the rate in effect.
    always_comb begin
        if (ack_d && (cur_sel_d != cur_sel_q)) begin
            tick_count_d = 16'h0000;
        end else if (tick_s && (tick_count_q != 16'hFFFF)) begin
            tick_count_d = tick_count_q + 16'h0001;
        end else begin
            tick_count_d = tick_count_q;
        end
    end

    // Tick counter register.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            tick_count_q <= 16'h0000;
        end else begin
            tick_count_q <= tick_count_d;
        end
    end

    assign tick_count = tick_count_q;
`else
    assign tick_count = 16'h0000;
`endif

endmodule

// File: doc/clk_rate_sequencer.md
Name: clk_rate_sequencer

Overview:
- Run-time controller for the board clock-divider chain. It generates one square-wave clock and a matching single-cycle tick from the 100 MHz board clock.
- A requester can switch between nine decade-spaced rates (50 MHz down to 1 Hz) through a req/ack handshake.
- Rate changes take effect only on a rising-edge boundary, so no runt pulses appear. The output feeds LEDs, PMOD pins and downstream logic that needs a selectable timebase.

Parameters:
- CLK_HZ, 100_000_000: input clock frequency; the half-period table is derived from it.
- RESET_SEL, 5: rate index loaded at reset (5 = 1 kHz).

Ports:
- CLK100MHZ  in  1  board clock, 100 MHz.
- CPU_RESETN  in  1  asynchronous active-low reset.
- en  in  1  run enable.
- rate_sel  in  4  requested rate index.
- req  in  1  rate-change request (level, sampled when busy=0).
- ack  out  1  one-cycle pulse: request completed or rejected.
- err  out  1  one-cycle pulse coincident with ack: index invalid.
- busy  out  1  request pending.
- cur_sel  out  4  rate index currently in effect.
- clk_out  out  1  divided square wave, 50% duty.
- tick  out  1  one-cycle pulse on each clk_out rising event.
- tick_count  out  16  see Optional Feature.

Behaviour:
- Rate table, HALF[i] = CLK_HZ/(2*f):
  - 0 = 50 MHz (1), 1 = 10 MHz (5), 2 = 1 MHz (50), 3 = 100 kHz (500), 4 = 10 kHz (5_000)
  - 5 = 1 kHz (50_000), 6 = 100 Hz (500_000), 7 = 10 Hz (5_000_000), 8 = 1 Hz (50_000_000)
  - Indices 9-15 are invalid.
- Counter: 26 bits, unsigned, counts 0..HALF[cur_sel]-1.
- Reset (CPU_RESETN=0, asynchronous):
  - state STOP, cur_sel=RESET_SEL.
  - clk_out, tick, ack, err, busy, counter, tick_count all 0.
  - Any pending request is discarded; no ack is issued for it after release.
- States: STOP, RUN, PEND.
- STOP:
  - clk_out=0, counter held at 0.
  - en=1 -> RUN. The first rise occurs HALF cycles later (low half first).
- RUN/PEND:
  - Counter increments each cycle.
  - At HALF-1: clk_out toggles and counter returns to 0.
  - tick=1 in the same cycle that clk_out goes 0->1 (registered; tick and clk_out rise on the same edge).
  - Sel 0: clk_out toggles every cycle; tick every 2nd cycle.
- Request acceptance:
  - req=1 && busy=0 latches rate_sel into pend_sel. Next cycle busy=1.
  - req while busy=1 is ignored.
  - Invalid index: err=1 and ack=1 one cycle after acceptance; busy never asserts; cur_sel unchanged.
  - pend_sel==cur_sel, or state STOP: cur_sel updates (if different) and ack=1 one cycle after acceptance; busy never asserts.
  - Otherwise RUN -> PEND.
- PEND:
  - At the next rising event (clk_out 0->1), cur_sel<=pend_sel, counter<=0, ack=1, busy=0, tick=1 -> RUN.
  - The high half after the switch uses the new HALF. The old rate's last low half completes unshortened.
- en=0 in RUN/PEND:
  - If clk_out=1: finish the high half; at the falling toggle go to STOP.
  - If clk_out=0: go to STOP at once; counter cleared.
  - If PEND when entering STOP: apply pend_sel, ack=1 in the entry cycle.
- Simultaneous events:
  - en falls in the same cycle as a PEND rising event: the switch and ack occur first, then the en=0 rule applies.
  - req accepted in the same cycle as ack: legal; it is handled as a new request.
- Minimum phase: no clk_out high or low phase is shorter than min(HALF_old, HALF_new) cycles.

Optional Feature:
- Macro: CLKSEQ_TICK_COUNT_EN.
- Defined:
  - tick_count increments on each tick, saturating at 16'hFFFF.
  - Clears to 0 in the cycle ack is issued with cur_sel changing.
- Undefined: tick_count is constant 0 and no counter is synthesised.

Decomposition:
- Package clk_seq_pkg holds:
  - constants NUM_RATES=9, SEL_W=4, CTR_W=26;
  - the HALF table as a constant function of CLK_HZ;
  - state enum {STOP, RUN, PEND}.
- Sub-module clk_seq_divider holds the counter, toggle and tick.
  - Inputs: half_cnt, run, load (load clears the counter).
  - Outputs: clk_out, tick, rise_next, fall_next (flags for the FSM).
- The FSM and handshake stay in clk_rate_sequencer.

Test Plan:
- Reset with RESET_SEL=5, then en=1 -> first clk_out rise and tick at cycle 50_000, then a tick every 100_000 cycles; clk_out high for 50_000 cycles.
- req with rate_sel=0 while stopped -> ack 1 cycle later; en=1 -> clk_out toggles every cycle, tick every 2 cycles.
- Running at sel 1, req rate_sel=2 -> busy=1 next cycle; ack at the next rising event; then period 100 cycles; no phase shorter than 5 cycles.
- req rate_sel=12 -> err and ack together 1 cycle later; busy stays 0; cur_sel unchanged; clk_out undisturbed.
- At sel 3, drop en while clk_out=1 -> clk_out falls at the 500-count boundary and stays 0; req rate_sel=4 in STOP -> ack in 1 cycle; cur_sel=4.
- Assert CPU_RESETN=0 during PEND -> all outputs at reset values immediately; no ack after release; cur_sel=RESET_SEL.
